// File: rtl/demux_8_1_sched_if.sv
// Handshake bundle between the word source, the 1:8 demux scheduler
// and the eight output channels.
interface demux_8_1_sched_if #(
  parameter int DW = 1
);
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [2:0]    in_dest;
  logic [2:0]    sel;
  logic [7:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [7:0]    out_ready;
  logic          drop;
  logic [7:0]    drop_cnt;

  modport master (
    output mode, in_valid, in_data, in_dest, out_ready,
    input  in_ready, sel, out_valid, out_data, drop, drop_cnt
  );

  modport slave (
    input  mode, in_valid, in_data, in_dest, out_ready,
    output in_ready, sel, out_valid, out_data, drop, drop_cnt
  );
endinterface

// File: rtl/demux_8_1_sched.sv
// 1:8 demux scheduler: addressed or round-robin channel choice,
// per-channel backpressure with drop-on-timeout and saturating drop count.
module demux_8_1_sched #(
  parameter int DW      = 1,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  demux_8_1_sched_if.slave bus
);

  localparam int WW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    rr_q, rr_d;
  logic          rrm_q, rrm_d;
  logic [DW-1:0] data_q, data_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          drop_q, drop_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          tmo_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      rrm_q   <= 1'b0;
      data_q  <= '0;
      wait_q  <= '0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      rrm_q   <= rrm_d;
      data_q  <= data_d;
      wait_q  <= wait_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tmo_hit = (TIMEOUT != 0) &&
                   (wait_q == WW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    rrm_d   = rrm_q;
    data_d  = data_q;
    wait_d  = wait_q;
    drop_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          sel_d   = bus.mode ? rr_q : bus.in_dest;
          rrm_d   = bus.mode;
          wait_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // completion has priority over a coincident timeout
        if (bus.out_ready[sel_q]) begin
          state_d = IDLE;
          if (rrm_q) rr_d = sel_q + 3'd1;
        end else if (tmo_hit) begin
          state_d = IDLE;
          drop_d  = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (rrm_q) rr_d = sel_q + 3'd1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !rst;
    bus.out_valid = '0;
    if (state_q == SEND) bus.out_valid = 8'b1 << sel_q;
    bus.sel       = sel_q;
    bus.out_data  = data_q;
    bus.drop      = drop_q;
    bus.drop_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_demux_8_1_sched.sv
// Directed bench for demux_8_1_sched: one TIMEOUT=15 instance and one
// TIMEOUT=0 instance sharing clock and reset.
module tb_demux_8_1_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  demux_8_1_sched_if #(.DW(1)) u0 ();
  demux_8_1_sched_if #(.DW(1)) u1 ();

  demux_8_1_sched #(.DW(1), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .bus(u0.slave)
  );

  demux_8_1_sched #(.DW(1), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(u1.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_cmp++;
    if (u0.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_ready: got %0b want 0", u0.in_ready);
    end
    n_cmp++;
    if (u0.out_valid !== 8'h00 || u0.sel !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_outs: got ov=%0h sel=%0d want 0/0",
               u0.out_valid, u0.sel);
    end
    n_cmp++;
    if (u0.drop !== 1'b0 || u0.drop_cnt !== 8'd0 ||
        u0.out_data !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_drop: got d=%0b cnt=%0d od=%0b want 0",
               u0.drop, u0.drop_cnt, u0.out_data);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (u0.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release: got in_ready=%0b want 1",
               u0.in_ready);
    end
  endtask

  task automatic test_addressed();
    u0.mode = 1'b0; u0.in_dest = 3'd5; u0.in_data = 1'b1;
    u0.out_ready = 8'hFF; u0.in_valid = 1'b1;
    step();
    u0.in_valid = 1'b0;
    n_cmp++;
    if (u0.sel !== 3'd5 || u0.out_valid !== 8'b0010_0000 ||
        u0.out_data !== 1'b1 || u0.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_present: got sel=%0d ov=%0h od=%0b rdy=%0b want 5/20/1/0",
               u0.sel, u0.out_valid, u0.out_data, u0.in_ready);
    end
    step();
    n_cmp++;
    if (u0.out_valid !== 8'h00 || u0.in_ready !== 1'b1 ||
        u0.drop !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_done: got ov=%0h rdy=%0b drop=%0b want 0/1/0",
               u0.out_valid, u0.in_ready, u0.drop);
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    u0.mode = 1'b1; u0.in_dest = 3'd6; u0.out_ready = 8'hFF;
    u0.in_data = 1'b1; u0.in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 19) u0.in_valid = 1'b0;
      if (u0.out_valid !== 8'h00) begin
        n_cmp++;
        if (u0.sel !== 3'(n % 8) ||
            u0.out_valid !== (8'h01 << (n % 8))) begin
          n_fail++;
          $display("FAIL rr_word%0d: got sel=%0d ov=%0h want sel=%0d",
                   n, u0.sel, u0.out_valid, n % 8);
        end
        n++;
      end
    end
    n_cmp++;
    if (n != 10 || u0.drop_cnt !== 8'd0 || u0.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_total: got words=%0d cnt=%0d rdy=%0b want 10/0/1",
               n, u0.drop_cnt, u0.in_ready);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    u0.mode = 1'b0; u0.in_dest = 3'd3; u0.in_data = 1'b1;
    u0.out_ready = 8'hF7; u0.in_valid = 1'b1;
    step();
    u0.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) u0.out_ready = 8'hFF;
      u0.mode = ~u0.mode;
      u0.in_dest = 3'(i);
      n_cmp++;
      if (u0.out_valid !== 8'b0000_1000 || u0.out_data !== 1'b1 ||
          u0.sel !== 3'd3 || u0.drop !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got ov=%0h od=%0b sel=%0d drop=%0b want 08/1/3/0",
                 i, u0.out_valid, u0.out_data, u0.sel, u0.drop);
      end
      step();
    end
    n_cmp++;
    if (u0.out_valid !== 8'h00 || u0.drop !== 1'b0 ||
        u0.drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL bp_done: got ov=%0h drop=%0b cnt=%0d want 0/0/0",
               u0.out_valid, u0.drop, u0.drop_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    u0.mode = 1'b1; u0.out_ready = 8'h00; u0.in_valid = 1'b1;
    step();
    u0.in_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      n_cmp++;
      if (u0.out_valid !== 8'h01 || u0.drop !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_wait%0d: got ov=%0h drop=%0b want 01/0",
                 i, u0.out_valid, u0.drop);
      end
      step();
    end
    n_cmp++;
    if (u0.drop !== 1'b1 || u0.drop_cnt !== 8'd1 ||
        u0.out_valid !== 8'h00) begin
      n_fail++;
      $display("FAIL tmo_drop: got drop=%0b cnt=%0d ov=%0h want 1/1/0",
               u0.drop, u0.drop_cnt, u0.out_valid);
    end
    u0.in_valid = 1'b1;
    step();
    u0.in_valid = 1'b0;
    n_cmp++;
    if (u0.sel !== 3'd1 || u0.out_valid !== 8'h02 ||
        u0.drop !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_next: got sel=%0d ov=%0h drop=%0b want 1/02/0",
               u0.sel, u0.out_valid, u0.drop);
    end
    for (int i = 0; i < 14; i++) step();
    u0.out_ready = 8'hFF;
    step();
    n_cmp++;
    if (u0.drop !== 1'b0 || u0.drop_cnt !== 8'd1 ||
        u0.out_valid !== 8'h00) begin
      n_fail++;
      $display("FAIL tmo_race: got drop=%0b cnt=%0d ov=%0h want 0/1/0",
               u0.drop, u0.drop_cnt, u0.out_valid);
    end
  endtask

  task automatic test_saturation();
    int drops = 0;
    do_reset();
    u0.mode = 1'b1; u0.out_ready = 8'h00;
    for (int w = 0; w < 301; w++) begin
      bit seen = 1'b0;
      u0.in_valid = 1'b1;
      step();
      u0.in_valid = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        step();
        if (u0.drop === 1'b1) seen = 1'b1;
      end
      if (seen) drops++;
      if (w == 299) begin
        n_cmp++;
        if (u0.drop_cnt !== 8'd255 || drops != 300) begin
          n_fail++;
          $display("FAIL sat_300: got cnt=%0d drops=%0d want 255/300",
                   u0.drop_cnt, drops);
        end
      end
    end
    n_cmp++;
    if (u0.drop_cnt !== 8'd255 || drops != 301) begin
      n_fail++;
      $display("FAIL sat_hold: got cnt=%0d drops=%0d want 255/301",
               u0.drop_cnt, drops);
    end
  endtask

  task automatic test_reset_mid_send();
    u0.mode = 1'b0; u0.in_dest = 3'd6; u0.out_ready = 8'h00;
    u0.in_valid = 1'b1;
    step();
    u0.in_valid = 1'b0;
    n_cmp++;
    if (u0.out_valid !== 8'h40) begin
      n_fail++;
      $display("FAIL mid_pre: got ov=%0h want 40", u0.out_valid);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (u0.out_valid !== 8'h00 || u0.sel !== 3'd0 ||
        u0.drop_cnt !== 8'd0 || u0.drop !== 1'b0 ||
        u0.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: got ov=%0h sel=%0d cnt=%0d drop=%0b rdy=%0b want 0/0/0/0/0",
               u0.out_valid, u0.sel, u0.drop_cnt, u0.drop, u0.in_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (u0.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_release: got rdy=%0b want 1", u0.in_ready);
    end
  endtask

  task automatic test_timeout_zero();
    bit dropped = 1'b0;
    u1.mode = 1'b0; u1.in_dest = 3'd2; u1.in_data = 1'b1;
    u1.out_ready = 8'h00; u1.in_valid = 1'b1;
    step();
    u1.in_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (u1.drop !== 1'b0) dropped = 1'b1;
    end
    n_cmp++;
    if (dropped || u1.drop_cnt !== 8'd0 || u1.out_valid !== 8'h04) begin
      n_fail++;
      $display("FAIL t0_nodrop: got dropped=%0b cnt=%0d ov=%0h want 0/0/04",
               dropped, u1.drop_cnt, u1.out_valid);
    end
    u1.out_ready = 8'h04;
    step();
    n_cmp++;
    if (u1.out_valid !== 8'h00 || u1.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL t0_done: got ov=%0h rdy=%0b want 0/1",
               u1.out_valid, u1.in_ready);
    end
  endtask

  initial begin
    u0.mode = 1'b0; u0.in_valid = 1'b0; u0.in_data = 1'b0;
    u0.in_dest = 3'd0; u0.out_ready = 8'h00;
    u1.mode = 1'b0; u1.in_valid = 1'b0; u1.in_data = 1'b0;
    u1.in_dest = 3'd0; u1.out_ready = 8'h00;
    test_reset();
    test_addressed();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_saturation();
    test_reset_mid_send();
    test_timeout_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
